// File: rtl/uart_pkg.sv
// Shared UART types and constants for the rx/tx extended paths.
package uart_pkg;

  localparam int CLK_DIV_115200 = 434;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER,
    S_BRKWAIT
  } rx_state_e;

  function automatic int clog2_div(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter with the three mid-bit sample strobes.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_early,
  output logic tick_mid,
  output logic tick_late
);
  localparam int CW   = clog2_div(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart)             cnt <= '0;
    else if (cnt == CW'(CLK_DIV - 1))  cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  assign tick_early = (cnt == CW'(HALF - 1));
  assign tick_mid   = (cnt == CW'(HALF));
  assign tick_late  = (cnt == CW'(HALF + 1));

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: majority-vote sampling, parity/stop checks,
// break detection and a valid/ready output with overrun reporting.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 8) begin : g_param_err
    $error("uart_rx_ext: illegal parameter set");
  end

  localparam logic PAR_TGT = logic'(PARITY == int'(PAR_ODD));
  localparam logic HAS_PAR = logic'(PARITY != int'(PAR_NONE));

  rx_state_e            state;
  logic                 sync1, s_rx, s_rx_d;
  logic                 v_early, v_mid, vote;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 pbit, perr_n, ferr_n, brk;
  logic                 tk_early, tk_mid, tk_late, restart;

  // Timer only runs while a frame is being sampled; everywhere else it sits at 0
  // so START always begins counting from the cycle after the edge.
  assign restart = (state == S_IDLE) || (state == S_DELIVER) || (state == S_BRKWAIT);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .tick_early (tk_early),
    .tick_mid   (tk_mid),
    .tick_late  (tk_late)
  );

  assign vote = (v_early & v_mid) | (v_early & s_rx) | (v_mid & s_rx);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      s_rx       <= 1'b1;
      s_rx_d     <= 1'b1;
      state      <= S_IDLE;
      v_early    <= 1'b1;
      v_mid      <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      pbit       <= 1'b0;
      perr_n     <= 1'b0;
      ferr_n     <= 1'b0;
      brk        <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      sync1   <= rs232_rx;
      s_rx    <= sync1;
      s_rx_d  <= s_rx;
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tk_early) v_early <= s_rx;
      if (tk_mid)   v_mid   <= s_rx;

      case (state)
        S_IDLE: if (s_rx_d && !s_rx) begin
          state    <= S_START;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          pbit     <= 1'b0;
          perr_n   <= 1'b0;
          ferr_n   <= 1'b0;
          brk      <= 1'b0;
        end
        // Timer is not restarted past START, so later votes stay mid-bit.
        S_START: if (tk_late) state <= vote ? S_IDLE : S_DATA;
        S_DATA: if (tk_late) begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'(DATA_BITS - 1)) state <= HAS_PAR ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tk_late) begin
          pbit   <= vote;
          perr_n <= ((^shreg) ^ vote) != PAR_TGT;
          state  <= S_STOP;
        end
        S_STOP: if (tk_late) begin
          stop_idx <= 1'b1;
          if (!vote) ferr_n <= 1'b1;
          if (!stop_idx && !vote && shreg == '0 && !(HAS_PAR && pbit)) begin
            brk       <= 1'b1;
            break_det <= 1'b1;
            state     <= S_DELIVER;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            state <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (!rx_valid || rx_ready) begin
            rx_data    <= shreg;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            rx_valid   <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= brk ? S_BRKWAIT : S_IDLE;
        end
        S_BRKWAIT: if (s_rx) begin
          state     <= S_IDLE;
          break_det <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three configurations (8N1, 7E1, 8N2) at 16 clk/bit,
// a frame-level model of delivery/handshake and directed literal checks.
module tb_uart_rx_ext;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] rdy  = 3'b000;

  logic [7:0] rxd0, rxd2;
  logic [6:0] rxd1;
  logic [2:0] v, pe, fe, ovr, brk, bsy;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_DIV(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line[0]), .rx_data(rxd0), .rx_valid(v[0]),
    .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
    .break_det(brk[0]), .busy(bsy[0]));
  uart_rx_ext #(.CLK_DIV(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line[1]), .rx_data(rxd1), .rx_valid(v[1]),
    .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
    .break_det(brk[1]), .busy(bsy[1]));
  uart_rx_ext #(.CLK_DIV(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(line[2]), .rx_data(rxd2), .rx_valid(v[2]),
    .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]),
    .break_det(brk[2]), .busy(bsy[2]));

  typedef struct {
    int         id;
    int         t;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       pend[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         ovr_cnt = 0;
  logic       mv[3], mpe[3], mfe[3], movr[3];
  logic [8:0] md[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Frame-level model: a frame lands at a known edge; it loads if the
  // holding slot is free or being drained, otherwise it is dropped with overrun.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) movr[i] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 1'b0; md[i] = '0; mpe[i] = 1'b0; mfe[i] = 1'b0;
      end
      pend.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit   due;
        exp_t e;
        due = 1'b0;
        for (int j = pend.size() - 1; j >= 0; j--) begin
          if (pend[j].id == i && pend[j].t == cyc) begin
            due = 1'b1; e = pend[j]; pend.delete(j);
          end
        end
        if (due) begin
          if (!mv[i] || rdy[i]) begin
            mv[i] = 1'b1; md[i] = e.d; mpe[i] = e.pe; mfe[i] = e.fe;
          end else begin
            movr[i] = 1'b1;
          end
        end else if (mv[i] && rdy[i]) begin
          mv[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] ad;
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       ad = {1'b0, rxd0};
          1:       ad = {2'b0, rxd1};
          default: ad = {1'b0, rxd2};
        endcase
        chk($sformatf("valid%0d", i), 32'(v[i]), 32'(mv[i]));
        chk($sformatf("overrun%0d", i), 32'(ovr[i]), 32'(movr[i]));
        if (mv[i]) begin
          chk($sformatf("data%0d", i), 32'(ad), 32'(md[i]));
          chk($sformatf("perr%0d", i), 32'(pe[i]), 32'(mpe[i]));
          chk($sformatf("ferr%0d", i), 32'(fe[i]), 32'(mfe[i]));
        end
      end
      if (ovr[0]) ovr_cnt++;
    end
  end

  // Caller must be at a negedge. pbit<0 sends the correct parity bit.
  task automatic send(input int id, input logic [8:0] d, input int nb, input int par,
                      input int pbit, input int nstop, input logic [1:0] stopv);
    logic [8:0] dm;
    logic       pb, pe_e, fe_e, brk_e;
    int         last;
    exp_t       e;
    logic       bq[$];
    dm = d & 9'((1 << nb) - 1);
    if (pbit < 0) pb = (par == 1) ? ~(^dm) : (^dm);
    else          pb = pbit[0];
    pe_e  = (par != 0) && (((^dm) ^ pb) != (par == 1));
    fe_e  = !stopv[0] || (nstop == 2 && !stopv[1]);
    brk_e = (dm == 0) && (par == 0 || !pb) && !stopv[0];
    bq.push_back(1'b0);
    for (int k = 0; k < nb; k++) bq.push_back(dm[k]);
    if (par != 0) bq.push_back(pb);
    bq.push_back(stopv[0]);
    if (nstop == 2) bq.push_back(stopv[1]);
    last = brk_e ? nb + 1 + ((par != 0) ? 1 : 0) : bq.size() - 1;
    // 2 sync flops + edge detect + last vote at HALF+1 + one DELIVER cycle
    e.id = id; e.t = cyc + 5 + last * C + C / 2 + 1;
    e.d = dm; e.pe = pe_e; e.fe = fe_e || brk_e;
    pend.push_back(e);
    foreach (bq[k]) begin
      line[id] = bq[k];
      repeat (C) @(negedge clk);
    end
    line[id] = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(v), 0);
    chk("rst_data0", 32'(rxd0), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_flags", {pe, fe, ovr, brk}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, ready high: valid for exactly one clk, 158 clks after the line drop
    rdy[0] = 1'b1;
    fork
      send(0, 9'h0A5, 8, 0, -1, 1, 2'b11);
      begin
        repeat (157) @(negedge clk);
        chk("a5_pre", 32'(v[0]), 0);
        @(negedge clk);
        chk("a5_rise", 32'(v[0]), 1);
        chk("a5_data", 32'(rxd0), 32'h A5);
        chk("a5_flags", {pe[0], fe[0]}, 0);
        @(negedge clk);
        chk("a5_fall", 32'(v[0]), 0);
      end
    join
    repeat (4) @(negedge clk);

    // 4-clk glitch is rejected as a false start
    line[0] = 1'b0;
    repeat (4) @(negedge clk);
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", 32'(bsy[0]), 1);
    repeat (14) @(negedge clk);
    chk("glitch_busy_lo", 32'(bsy[0]), 0);
    chk("glitch_valid", 32'(v[0]), 0);

    // back-to-back frames with ready low: second is dropped with overrun
    rdy[0] = 1'b0;
    send(0, 9'h011, 8, 0, -1, 1, 2'b11);
    send(0, 9'h022, 8, 0, -1, 1, 2'b11);
    chk("ovr_data", 32'(rxd0), 32'h11);
    chk("ovr_count", 32'(ovr_cnt), 1);
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drain", 32'(v[0]), 0);
    rdy[0] = 1'b0;

    // 20 bit times of low line: break, word 0x00 with frame error
    begin
      exp_t e;
      e.id = 0; e.t = cyc + 5 + 9 * C + C / 2 + 1; e.d = '0; e.pe = 1'b0; e.fe = 1'b1;
      pend.push_back(e);
    end
    line[0] = 1'b0;
    repeat (20 * C) @(negedge clk);
    chk("brk_det", 32'(brk[0]), 1);
    chk("brk_busy", 32'(bsy[0]), 1);
    chk("brk_valid", 32'(v[0]), 1);
    chk("brk_data", 32'(rxd0), 0);
    chk("brk_ferr", 32'(fe[0]), 1);
    line[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_clear", 32'(brk[0]), 0);
    chk("brk_idle", 32'(bsy[0]), 0);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;

    send(0, 9'h055, 8, 0, -1, 1, 2'b11);
    chk("x55_data", 32'(rxd0), 32'h55);
    chk("x55_flags", {pe[0], fe[0], brk[0]}, 0);

    // 7E1: wrong parity then correct parity
    send(1, 9'h041, 7, 2, 1, 1, 2'b11);
    chk("e7_bad_data", 32'(rxd1), 32'h41);
    chk("e7_bad_perr", 32'(pe[1]), 1);
    rdy[1] = 1'b1;
    @(negedge clk);
    rdy[1] = 1'b0;
    send(1, 9'h041, 7, 2, 0, 1, 2'b11);
    chk("e7_ok_perr", 32'(pe[1]), 0);
    chk("e7_ok_valid", 32'(v[1]), 1);

    // 8N2 with the second stop bit low
    send(2, 9'h03C, 8, 0, -1, 2, 2'b01);
    chk("n2_data", 32'(rxd2), 32'h3C);
    chk("n2_ferr", 32'(fe[2]), 1);

    // reset in the middle of a frame while a word is still held
    @(negedge clk);
    line[0] = 1'b0;
    repeat (3 * C) @(negedge clk);
    chk("mid_busy", 32'(bsy[0]), 1);
    rst_n   = 1'b0;
    line[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(v), 0);
    chk("mid_rst_data", 32'(rxd0), 0);
    chk("mid_rst_busy", 32'(bsy), 0);
    chk("mid_rst_flags", {pe, fe, ovr, brk}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
